// File: rtl/psram_qpi_responder_if.sv
// Link-side signal bundle between a PSRAM initiator (master) and the responder (slave).
// Optional PSRAM_RESP_STATS_EN adds the rd_words/wr_words counters to both modports.
interface psram_qpi_responder_if;
  logic        mem_ce;
  logic [3:0]  sio_in;
  logic [3:0]  sio_out;
  logic        sio_oe;
  logic        qpi_mode;
  logic        busy;
  logic        cmd_err;
`ifdef PSRAM_RESP_STATS_EN
  logic [15:0] rd_words;
  logic [15:0] wr_words;

  modport master (output mem_ce, sio_in,
                  input  sio_out, sio_oe, qpi_mode, busy, cmd_err, rd_words, wr_words);
  modport slave  (input  mem_ce, sio_in,
                  output sio_out, sio_oe, qpi_mode, busy, cmd_err, rd_words, wr_words);
`else
  modport master (output mem_ce, sio_in,
                  input  sio_out, sio_oe, qpi_mode, busy, cmd_err);
  modport slave  (input  mem_ce, sio_in,
                  output sio_out, sio_oe, qpi_mode, busy, cmd_err);
`endif
endinterface

// File: rtl/psram_qpi_responder.sv
// Device-side model of an LY68L6400 PSRAM: SPI init commands, QPI EBh read / 38h write into word RAM.
// Define PSRAM_RESP_STATS_EN to add saturating rd_words/wr_words transfer counters.
module psram_qpi_responder #(
  parameter int AW          = 10,
  parameter int WAIT_CYCLES = 6
) (
  input logic                  mem_clk,
  input logic                  rst,
  psram_qpi_responder_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE, SPI_CMD, Q_CMD, Q_ADDR, Q_WAIT, Q_RDATA, Q_WDATA, IGNORE
  } state_e;

  localparam int         SHW       = (AW > 12) ? AW : 12;
  localparam logic [4:0] LAST_WAIT = 5'(7 + WAIT_CYCLES);

  state_e           state_q, state_d;
  logic [4:0]       cnt_q, cnt_d;
  logic [SHW-1:0]   shift_q, shift_d;
  logic [AW-1:0]    ptr_q, ptr_d;
  logic [1:0]       nib_q, nib_d;
  logic [15:0]      word_q, word_d;
  logic             isWr_q, isWr_d;
  logic [3:0]       sioOut_q, sioOut_d;
  logic             sioOe_q, sioOe_d;
  logic             qpi_q, qpi_d;
  logic             busy_q, busy_d;
  logic             cmdErr_q, cmdErr_d;
  logic             rstEn_q, rstEn_d;
`ifdef PSRAM_RESP_STATS_EN
  logic [15:0]      rdCnt_q, rdCnt_d;
  logic [15:0]      wrCnt_q, wrCnt_d;
`endif

  logic [15:0]      mem_q [2**AW];
  logic             ramWe;
  logic [15:0]      ramWdata;
  logic [15:0]      rdWord;
  logic [SHW-1:0]   spiShift, nibShift;
  logic [7:0]       opcode;

  // Next-state and output decode; every edge with mem_ce low advances the transaction by one step.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shift_d  = shift_q;
    ptr_d    = ptr_q;
    nib_d    = nib_q;
    word_d   = word_q;
    isWr_d   = isWr_q;
    sioOut_d = sioOut_q;
    sioOe_d  = sioOe_q;
    qpi_d    = qpi_q;
    busy_d   = busy_q;
    cmdErr_d = cmdErr_q;
    rstEn_d  = rstEn_q;
`ifdef PSRAM_RESP_STATS_EN
    rdCnt_d  = rdCnt_q;
    wrCnt_d  = wrCnt_q;
`endif
    ramWe    = 1'b0;
    ramWdata = {shift_q[11:0], bus.sio_in};
    rdWord   = mem_q[ptr_q];
    spiShift = {shift_q[SHW-2:0], bus.sio_in[0]};
    nibShift = {shift_q[SHW-5:0], bus.sio_in};
    opcode   = qpi_q ? nibShift[7:0] : spiShift[7:0];

    if (bus.mem_ce) begin
      state_d = IDLE;
      sioOe_d = 1'b0;
      busy_d  = 1'b0;
    end else begin
      busy_d = 1'b1;
      unique case (state_q)
        IDLE: begin
          shift_d = qpi_q ? nibShift : spiShift;
          cnt_d   = 5'd1;
          state_d = qpi_q ? Q_CMD : SPI_CMD;
        end
        SPI_CMD, Q_CMD: begin
          shift_d = qpi_q ? nibShift : spiShift;
          cnt_d   = cnt_q + 5'd1;
          if (state_q == Q_CMD || cnt_q == 5'd7) begin
            state_d = IGNORE;
            // 35h is only an entry command from SPI; in QPI it is treated as unknown
            if (state_q == Q_CMD && (opcode == 8'hEB || opcode == 8'h38)) begin
              isWr_d  = (opcode == 8'h38);
              state_d = Q_ADDR;
            end else if (opcode == 8'h66) begin
              rstEn_d = 1'b1;
            end else if (opcode == 8'h99) begin
              if (rstEn_q) begin
                qpi_d    = 1'b0;
                cmdErr_d = 1'b0;
              end
              rstEn_d = 1'b0;
            end else if (opcode == 8'h35 && !qpi_q) begin
              qpi_d   = 1'b1;
              rstEn_d = 1'b0;
            end else begin
              cmdErr_d = 1'b1;
              rstEn_d  = 1'b0;
            end
          end
        end
        Q_ADDR: begin
          shift_d = nibShift;
          cnt_d   = cnt_q + 5'd1;
          if (cnt_q == 5'd7) begin
            ptr_d   = {shift_q[AW-5:0], bus.sio_in};
            nib_d   = 2'd0;
            state_d = isWr_q ? Q_WDATA : Q_WAIT;
          end
        end
        Q_WAIT: begin
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == LAST_WAIT) begin
            sioOe_d  = 1'b1;
            sioOut_d = rdWord[15:12];
            word_d   = rdWord;
            nib_d    = 2'd1;
            state_d  = Q_RDATA;
          end
        end
        Q_RDATA: begin
          nib_d = nib_q + 2'd1;
          unique case (nib_q)
            2'd0: begin
              word_d   = rdWord;
              sioOut_d = rdWord[15:12];
            end
            2'd1: sioOut_d = word_q[11:8];
            2'd2: sioOut_d = word_q[7:4];
            default: begin
              sioOut_d = word_q[3:0];
              ptr_d    = ptr_q + 1'b1;
`ifdef PSRAM_RESP_STATS_EN
              if (rdCnt_q != 16'hFFFF) rdCnt_d = rdCnt_q + 16'd1;
`endif
            end
          endcase
        end
        Q_WDATA: begin
          shift_d = nibShift;
          nib_d   = nib_q + 2'd1;
          if (nib_q == 2'd3) begin
            ramWe = 1'b1;
            ptr_d = ptr_q + 1'b1;
`ifdef PSRAM_RESP_STATS_EN
            if (wrCnt_q != 16'hFFFF) wrCnt_d = wrCnt_q + 16'd1;
`endif
          end
        end
        default: ;
      endcase
    end
  end

  // State register; reset wins over mem_ce and abandons any transaction in flight.
  always_ff @(posedge mem_clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      shift_q  <= '0;
      ptr_q    <= '0;
      nib_q    <= '0;
      word_q   <= '0;
      isWr_q   <= 1'b0;
      sioOut_q <= '0;
      sioOe_q  <= 1'b0;
      qpi_q    <= 1'b0;
      busy_q   <= 1'b0;
      cmdErr_q <= 1'b0;
      rstEn_q  <= 1'b0;
`ifdef PSRAM_RESP_STATS_EN
      rdCnt_q  <= '0;
      wrCnt_q  <= '0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shift_q  <= shift_d;
      ptr_q    <= ptr_d;
      nib_q    <= nib_d;
      word_q   <= word_d;
      isWr_q   <= isWr_d;
      sioOut_q <= sioOut_d;
      sioOe_q  <= sioOe_d;
      qpi_q    <= qpi_d;
      busy_q   <= busy_d;
      cmdErr_q <= cmdErr_d;
      rstEn_q  <= rstEn_d;
`ifdef PSRAM_RESP_STATS_EN
      rdCnt_q  <= rdCnt_d;
      wrCnt_q  <= wrCnt_d;
`endif
    end
  end

  // Word RAM keeps its contents across reset.
  always_ff @(posedge mem_clk) begin
    if (!rst && ramWe) mem_q[ptr_q] <= ramWdata;
  end

  assign bus.sio_out  = sioOut_q;
  assign bus.sio_oe   = sioOe_q;
  assign bus.qpi_mode = qpi_q;
  assign bus.busy     = busy_q;
  assign bus.cmd_err  = cmdErr_q;
`ifdef PSRAM_RESP_STATS_EN
  assign bus.rd_words = rdCnt_q;
  assign bus.wr_words = wrCnt_q;
`endif

endmodule

// File: tb/tb_psram_qpi_responder.sv
// Randomized bench for psram_qpi_responder against a word-array model of the PSRAM command rules.
// Also covers the PSRAM_RESP_STATS_EN counters when that macro is defined.
module tb_psram_qpi_responder;

  localparam int AW    = 10;
  localparam int WC    = 6;
  localparam int DEPTH = 1 << AW;

  logic mem_clk = 1'b0;
  logic rst;
  psram_qpi_responder_if bus ();

  psram_qpi_responder #(.AW(AW), .WAIT_CYCLES(WC)) dut (
    .mem_clk (mem_clk),
    .rst     (rst),
    .bus     (bus)
  );

  always #5 mem_clk = ~mem_clk;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] modelMem [DEPTH];
  bit          modelQpi, modelErr, modelRstEn;
  int          modelRd, modelWr;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
    end
  endtask

  // One link edge: initiator drives on the falling edge, outputs are looked at 1 ns after the rising edge.
  task automatic applyStimulus(input logic ce, input logic [3:0] nib);
    @(negedge mem_clk);
    bus.mem_ce = ce;
    bus.sio_in = nib;
    @(posedge mem_clk);
    #1;
  endtask

  task automatic endFrame;
    applyStimulus(1'b1, 4'h0);
    checkOutput("oeAfterCe", 32'(bus.sio_oe), 32'd0);
    checkOutput("busyAfterCe", 32'(bus.busy), 32'd0);
    applyStimulus(1'b1, 4'h0);
  endtask

  task automatic checkMode(input string tag);
    checkOutput({tag, "_qpi"}, 32'(bus.qpi_mode), 32'(modelQpi));
    checkOutput({tag, "_err"}, 32'(bus.cmd_err), 32'(modelErr));
  endtask

  task automatic checkStats;
`ifdef PSRAM_RESP_STATS_EN
    checkOutput("rdWords", 32'(bus.rd_words), (modelRd > 65535) ? 32'd65535 : 32'(modelRd));
    checkOutput("wrWords", 32'(bus.wr_words), (modelWr > 65535) ? 32'd65535 : 32'(modelWr));
`endif
  endtask

  // Command rules for the non-transfer opcodes, shared by SPI and QPI framing.
  function automatic void modelCommand(input logic [7:0] op);
    if (op == 8'h66) modelRstEn = 1'b1;
    else if (op == 8'h99) begin
      if (modelRstEn) begin
        modelQpi = 1'b0;
        modelErr = 1'b0;
      end
      modelRstEn = 1'b0;
    end else if (op == 8'h35 && !modelQpi) begin
      modelQpi   = 1'b1;
      modelRstEn = 1'b0;
    end else begin
      modelErr   = 1'b1;
      modelRstEn = 1'b0;
    end
  endfunction

  task automatic spiCmd(input logic [7:0] op);
    for (int i = 7; i >= 0; i--) applyStimulus(1'b0, {3'b000, op[i]});
    checkOutput("spiBusy", 32'(bus.busy), 32'd1);
    endFrame();
    modelCommand(op);
    checkMode($sformatf("spi%02h", op));
  endtask

  task automatic qpiCmd(input logic [7:0] op);
    applyStimulus(1'b0, op[7:4]);
    applyStimulus(1'b0, op[3:0]);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 4'($urandom));
    checkOutput("qpiCmdOe", 32'(bus.sio_oe), 32'd0);
    endFrame();
    modelCommand(op);
    checkMode($sformatf("qpi%02h", op));
  endtask

  task automatic sendHeader(input logic [7:0] op, input logic [23:0] addr);
    applyStimulus(1'b0, op[7:4]);
    applyStimulus(1'b0, op[3:0]);
    for (int i = 5; i >= 0; i--) applyStimulus(1'b0, addr[4*i +: 4]);
  endtask

  // Write nnib nibbles taken MSB-first from data; only whole 4-nibble words land in memory.
  task automatic qpiWrite(input logic [23:0] addr, input int nnib, input logic [63:0] data);
    sendHeader(8'h38, addr);
    for (int j = 0; j < nnib; j++) applyStimulus(1'b0, data[60 - 4*j +: 4]);
    endFrame();
    for (int w = 0; w < nnib / 4; w++)
      modelMem[(int'(addr) + w) % DEPTH] = data[48 - 16*w +: 16];
    modelWr += nnib / 4;
  endtask

  task automatic qpiRead(input logic [23:0] addr, input int nwords);
    logic [15:0] word;
    int          k;
    sendHeader(8'hEB, addr);
    for (int e = 8; e <= 7 + WC + 4*nwords - 1; e++) begin
      applyStimulus(1'b0, 4'($urandom));
      if (e < 7 + WC) begin
        checkOutput($sformatf("waitOe_e%0d", e), 32'(bus.sio_oe), 32'd0);
      end else begin
        k    = e - 7 - WC;
        word = modelMem[(int'(addr) + k / 4) % DEPTH];
        checkOutput($sformatf("rdNib_%06h_k%0d", addr, k), 32'(bus.sio_out), 32'((word >> (4 * (3 - k % 4))) & 16'hF));
        checkOutput("rdOe", 32'(bus.sio_oe), 32'd1);
      end
    end
    endFrame();
    modelRd += nwords;
  endtask

  initial begin
    logic [7:0] op;
    int         sel;
    rst        = 1'b1;
    bus.mem_ce = 1'b1;
    bus.sio_in = 4'h0;
    modelQpi   = 1'b0;
    modelErr   = 1'b0;
    modelRstEn = 1'b0;
    modelRd    = 0;
    modelWr    = 0;
    repeat (3) applyStimulus(1'b1, 4'h0);
    checkOutput("rstOut", 32'(bus.sio_out), 32'd0);
    checkOutput("rstOe", 32'(bus.sio_oe), 32'd0);
    checkOutput("rstBusy", 32'(bus.busy), 32'd0);
    checkMode("rst");
    checkStats();
    rst = 1'b0;
    applyStimulus(1'b1, 4'h0);

    spiCmd(8'h66);
    spiCmd(8'h99);
    spiCmd(8'h35);

    for (int i = 0; i < DEPTH / 4; i++) qpiWrite(24'(4 * i), 16, {$urandom, $urandom});

    qpiWrite(24'h000005, 4, {16'hA5C3, 48'h0});
    qpiRead(24'h000005, 1);
    qpiWrite(24'h0003FF, 8, {16'h1234, 16'h5678, 32'h0});
    qpiRead(24'h0003FF, 2);
    qpiWrite(24'h000010, 6, {16'hBEEF, 16'hCA00, 32'h0});
    qpiRead(24'h000010, 2);
    checkStats();

    for (int it = 0; it < 30; it++) begin
      sel = $urandom_range(0, 5);
      if (sel < 3)
        qpiWrite(24'($urandom), $urandom_range(1, 16), {$urandom, $urandom});
      else if (sel < 5)
        qpiRead(24'($urandom), $urandom_range(1, 3));
      else begin
        op = 8'($urandom);
        if (op == 8'h66 || op == 8'h99 || op == 8'hEB || op == 8'h38) op = 8'h12;
        qpiCmd(op);
      end
      checkMode("rand");
    end
    checkStats();

    qpiCmd(8'h12);
    qpiCmd(8'h66);
    qpiCmd(8'h99);

    spiCmd(8'h03);
    spiCmd(8'h99);
    spiCmd(8'h66);
    spiCmd(8'h99);
    spiCmd(8'h35);

    // Reset in the middle of a read, after the read data has started driving.
    sendHeader(8'hEB, 24'h000005);
    for (int e = 8; e <= 7 + WC + 1; e++) applyStimulus(1'b0, 4'h0);
    checkOutput("preRstOe", 32'(bus.sio_oe), 32'd1);
    @(negedge mem_clk);
    rst = 1'b1;
    @(posedge mem_clk);
    #1;
    modelQpi   = 1'b0;
    modelErr   = 1'b0;
    modelRstEn = 1'b0;
    modelRd    = 0;
    modelWr    = 0;
    checkOutput("midRstOe", 32'(bus.sio_oe), 32'd0);
    checkOutput("midRstBusy", 32'(bus.busy), 32'd0);
    checkMode("midRst");
    checkStats();
    @(negedge mem_clk);
    rst        = 1'b0;
    bus.mem_ce = 1'b1;
    applyStimulus(1'b1, 4'h0);

    spiCmd(8'h35);
    qpiRead(24'h000005, 1);
    qpiRead(24'h0003FF, 2);
    checkStats();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
